// File: rtl/simd_seq.sv
// Command sequencer for a 4x32-bit SIMD array: reads two 128-bit operands,
// writes the array result back, one vector every four cycles.
module simd_seq #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_src1,
    input  logic [ADDR_W-1:0] i_cmd_src2,
    input  logic [ADDR_W-1:0] i_cmd_dst,
    input  logic [LEN_W-1:0]  i_cmd_len,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd_en,
    input  logic [127:0]      i_mem_rdata,
    output logic              o_mem_wr_en,
    output logic [127:0]      o_mem_wdata,
    output logic [127:0]      o_simd_in1,
    output logic [127:0]      o_simd_in2,
    output logic [1:0]        o_simd_opcode,
    input  logic [127:0]      i_simd_res,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD1, S_RD2, S_EXEC, S_WR, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic [LEN_W-1:0]  len_q, idx_q;
    logic [127:0]      op1_q, op2_q;
    logic              hs, last;
    logic [ADDR_W-1:0] idx_ext;

    assign hs      = i_cmd_valid && (state == S_IDLE);
    assign last    = (idx_q == len_q - LEN_W'(1));
    assign idx_ext = ADDR_W'(idx_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = (i_cmd_len == '0) ? S_DONE : S_RD1;
            S_RD1:   if (i_en) state_nxt = S_RD2;
            S_RD2:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WR;
            S_WR:    state_nxt = last ? S_DONE : S_RD1;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address is forced to zero whenever no strobe is active.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_idle      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_rd_en = 1'b0;
        o_mem_wr_en = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                o_idle      = 1'b1;
            end
            S_RD1: begin
                o_busy = 1'b1;
                if (i_en) begin
                    o_mem_rd_en = 1'b1;
                    o_mem_addr  = src1_q + idx_ext;
                end
            end
            S_RD2: begin
                o_busy      = 1'b1;
                o_mem_rd_en = 1'b1;
                o_mem_addr  = src2_q + idx_ext;
            end
            S_EXEC: o_busy = 1'b1;
            S_WR: begin
                o_busy      = 1'b1;
                o_mem_wr_en = 1'b1;
                o_mem_addr  = dst_q + idx_ext;
                o_mem_wdata = i_simd_res;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else begin
            if (hs) begin
                op_q   <= i_cmd_op;
                src1_q <= i_cmd_src1;
                src2_q <= i_cmd_src2;
                dst_q  <= i_cmd_dst;
                len_q  <= i_cmd_len;
                idx_q  <= '0;
            end
            // Read data lands one cycle after its strobe: op1 in RD2, op2 in EXEC.
            if (state == S_RD2)  op1_q <= i_mem_rdata;
            if (state == S_EXEC) op2_q <= i_mem_rdata;
            if (state == S_WR && !last) idx_q <= idx_q + LEN_W'(1);
        end
    end

    assign o_simd_in1    = op1_q;
    assign o_simd_in2    = op2_q;
    assign o_simd_opcode = op_q;

endmodule

// File: tb/tb_simd_seq.sv
// Directed bench for simd_seq with a 1-cycle-latency memory and a lane-wise
// SIMD array (0 add, 1 sub, 2 and, 3 xor) around the sequencer.
module tb_simd_seq;

    localparam int AW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0, rstn = 1'b0, en = 1'b1, cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] src1 = '0, src2 = '0, dst = '0;
    logic [LW-1:0] len = '0;
    logic          cmd_ready, mem_rd_en, mem_wr_en, idle, busy, done;
    logic [AW-1:0] mem_addr;
    logic [127:0]  mem_rdata = '0, mem_wdata, simd_in1, simd_in2, simd_res;
    logic [1:0]    simd_op;

    logic [127:0]  mem [int];

    simd_seq #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_src1(src1), .i_cmd_src2(src2), .i_cmd_dst(dst), .i_cmd_len(len),
        .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en), .i_mem_rdata(mem_rdata),
        .o_mem_wr_en(mem_wr_en), .o_mem_wdata(mem_wdata),
        .o_simd_in1(simd_in1), .o_simd_in2(simd_in2), .o_simd_opcode(simd_op),
        .i_simd_res(simd_res),
        .o_idle(idle), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int busy_cnt = 0, done_cnt = 0, hs_cnt = 0, ovl = 0, addr_bad = 0;
    logic [AW-1:0] rd_a[$], wr_a[$];
    logic [127:0]  wr_d[$];

    function automatic logic [127:0] rdmem(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= rdmem(mem_addr);
            rd_a.push_back(mem_addr);
        end
        if (mem_wr_en) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (cmd_valid && cmd_ready) hs_cnt++;
        if (mem_rd_en && mem_wr_en) ovl++;
        if (!mem_rd_en && !mem_wr_en && mem_addr != '0) addr_bad++;
    end

    always_comb begin
        simd_res = '0;
        for (int l = 0; l < 4; l++) begin
            case (simd_op)
                2'd0: simd_res[l*32 +: 32] = simd_in1[l*32 +: 32] + simd_in2[l*32 +: 32];
                2'd1: simd_res[l*32 +: 32] = simd_in1[l*32 +: 32] - simd_in2[l*32 +: 32];
                2'd2: simd_res[l*32 +: 32] = simd_in1[l*32 +: 32] & simd_in2[l*32 +: 32];
                default: simd_res[l*32 +: 32] = simd_in1[l*32 +: 32] ^ simd_in2[l*32 +: 32];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c, input logic [LW-1:0] n, input bit hold);
        int t = 0;
        @(negedge clk);
        cmd_op = op; src1 = a; src2 = b; dst = c; len = n; cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) chk("accept_timeout", 128'(t), 128'd0);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // cyc = edges from the accepting edge until o_done is seen.
    task automatic run(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [LW-1:0] n,
                       input bit hold, input bit stall, output int cyc);
        issue(op, a, b, c, n, hold);
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 200) begin
            if (stall && cyc == 3) en = 1'b0;
            if (stall && cyc == 9) en = 1'b1;
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        if (cyc == 200) chk("done_timeout", 128'(cyc), 128'd0);
        @(negedge clk);
        chk("back_to_idle", 128'(idle), 128'd1);
    endtask

    int cyc, rb, wb, bb, db, hb;

    task automatic mark();
        rb = rd_a.size(); wb = wr_a.size(); bb = busy_cnt; db = done_cnt; hb = hs_cnt;
    endtask

    initial begin
        mem[32'h10]   = 128'h00000001_00000002_00000003_00000004;
        mem[32'h20]   = 128'h00000010_00000020_00000030_00000040;
        mem[32'h40]   = 128'h00000050_00000060_00000070_00000080;
        mem[32'h50]   = 128'h00000005_00000006_00000007_00000008;
        mem[32'h41]   = 128'h00000000_00000000_00000000_00000001;
        mem[32'h51]   = 128'h00000000_00000000_00000000_00000002;
        mem[32'h42]   = 128'hAAAA0000_00000000_00000000_00000000;
        mem[32'h52]   = 128'hAAAA0000_00000000_00000000_00000000;
        mem[32'hFFFF] = {4{32'hF0F0F0F0}};
        mem[32'h100]  = {4{32'hFF00FF00}};
        mem[32'h0]    = {4{32'hFFFFFFFF}};
        mem[32'h101]  = {4{32'h12345678}};
        mem[32'h300]  = 128'hFFFFFFFF_00000000_00000000_00000000;
        mem[32'h400]  = 128'h0F0F0F0F_00000000_00000000_00000000;
        mem[32'h301]  = 128'h00000001_00000001_00000001_00000001;
        mem[32'h401]  = 128'h00000001_00000001_00000001_00000001;

        // Reset state
        #1;
        chk("rst_status", 128'({idle, cmd_ready, busy, done, mem_rd_en, mem_wr_en}), 128'b110000);
        chk("rst_addr", 128'(mem_addr), 128'd0);
        chk("rst_simd", {simd_in1 | simd_in2 | mem_wdata}, 128'd0);
        chk("rst_op", 128'(simd_op), 128'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // len=1 add
        mark();
        run(2'd0, 16'h10, 16'h20, 16'h30, 8'd1, 1'b0, 1'b0, cyc);
        chk("t1_cycles", 128'(cyc), 128'd4);
        chk("t1_rd0", 128'(rd_a[rb]), 128'h10);
        chk("t1_rd1", 128'(rd_a[rb+1]), 128'h20);
        chk("t1_wr_addr", 128'(wr_a[wb]), 128'h30);
        chk("t1_wr_data", wr_d[wb], 128'h00000011_00000022_00000033_00000044);
        chk("t1_done", 128'(done_cnt - db), 128'd1);

        // len=3 sub, valid held high while busy
        mark();
        run(2'd1, 16'h40, 16'h50, 16'h60, 8'd3, 1'b1, 1'b0, cyc);
        chk("t2_cycles", 128'(cyc), 128'd12);
        chk("t2_busy", 128'(busy_cnt - bb), 128'd12);
        chk("t2_hs", 128'(hs_cnt - hb), 128'd1);
        chk("t2_nwr", 128'(wr_a.size() - wb), 128'd3);
        chk("t2_wa0", 128'(wr_a[wb]), 128'h60);
        chk("t2_wa1", 128'(wr_a[wb+1]), 128'h61);
        chk("t2_wa2", 128'(wr_a[wb+2]), 128'h62);
        chk("t2_wd0", wr_d[wb], 128'h0000004B_0000005A_00000069_00000078);
        chk("t2_wd1", wr_d[wb+1], 128'h00000000_00000000_00000000_FFFFFFFF);
        chk("t2_wd2", wr_d[wb+2], 128'd0);
        chk("t2_done", 128'(done_cnt - db), 128'd1);

        // len=0
        mark();
        run(2'd0, 16'h10, 16'h20, 16'h30, 8'd0, 1'b0, 1'b0, cyc);
        chk("t3_cycles", 128'(cyc), 128'd0);
        chk("t3_strobes", 128'((rd_a.size() - rb) + (wr_a.size() - wb)), 128'd0);
        chk("t3_done", 128'(done_cnt - db), 128'd1);

        // address wrap, and
        mark();
        run(2'd2, 16'hFFFF, 16'h0100, 16'h0200, 8'd2, 1'b0, 1'b0, cyc);
        chk("t4_rd2_wrap", 128'(rd_a[rb+2]), 128'h0000);
        chk("t4_rd3", 128'(rd_a[rb+3]), 128'h0101);
        chk("t4_wa1", 128'(wr_a[wb+1]), 128'h0201);
        chk("t4_wd0", wr_d[wb], {4{32'hF000F000}});
        chk("t4_wd1", wr_d[wb+1], {4{32'h12345678}});

        // en low for 5 cycles at the second vector, xor
        mark();
        run(2'd3, 16'h300, 16'h400, 16'h500, 8'd2, 1'b0, 1'b1, cyc);
        chk("t5_cycles", 128'(cyc), 128'd13);
        chk("t5_nrd", 128'(rd_a.size() - rb), 128'd4);
        chk("t5_rd2", 128'(rd_a[rb+2]), 128'h301);
        chk("t5_wd0", wr_d[wb], 128'hF0F0F0F0_00000000_00000000_00000000);
        chk("t5_wa1", 128'(wr_a[wb+1]), 128'h501);

        // reset during EXEC of vector 1
        mark();
        issue(2'd1, 16'h10, 16'h20, 16'h30, 8'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_in_exec", 128'({busy, mem_rd_en, mem_wr_en}), 128'b100);
        rstn = 1'b0;
        #1;
        chk("t6_rst_status", 128'({idle, cmd_ready, busy, done, mem_rd_en, mem_wr_en}), 128'b110000);
        chk("t6_rst_simd", simd_in1, 128'd0);
        chk("t6_rst_op", 128'(simd_op), 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_no_wr", 128'(wr_a.size() - wb), 128'd0);
        chk("t6_no_done", 128'(done_cnt - db), 128'd0);
        mark();
        run(2'd0, 16'h10, 16'h20, 16'h30, 8'd1, 1'b0, 1'b0, cyc);
        chk("t6_rerun_cycles", 128'(cyc), 128'd4);
        chk("t6_rerun_wd", wr_d[wb], 128'h00000011_00000022_00000033_00000044);

        chk("rd_wr_overlap", 128'(ovl), 128'd0);
        chk("addr_idle_zero", 128'(addr_bad), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
